// File: rtl/turn_controller_pkg.sv
// turn_controller_pkg: shared state type, field widths and chicken start-position helper
package turn_controller_pkg;
  localparam int POS_W = 5;
  localparam int IMG_W = 4;
  localparam int PLAYER_W = 2;
  typedef enum logic [2:0] {IDLE, WAIT_FLIP, COMPARE, ADVANCE, DONE} state_t;
  function automatic logic [POS_W-1:0] start_pos(input int i, input int track_len, input int num_players);
    return POS_W'(i * (track_len / num_players));
  endfunction
endpackage

// File: rtl/turn_timer.sv
// turn_timer: counts idle WAIT_FLIP cycles and flags the cycle in which the turn expires
// Ports: clk, rst (sync, active-high), clr (restart count), en (count this cycle),
//        expired (combinational, high in the TIMEOUT_CYCLES-th enabled cycle).
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  assign expired = en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst || clr || expired) r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/turn_controller.sv
// turn_controller: turn sequencing, image compare and chicken movement for a tile-matching race game
// Ports: clk, rst (sync, active-high), start/flip pulses, center_img/edge_img images,
//        edge_addr (tile ahead of current chicken), player, pos_flat (5 bits per player),
//        match/miss/timeout pulses, game_over level and winner.
// Optional: define TURN_TIMEOUT_EN to pass the turn after TIMEOUT_CYCLES idle cycles.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int TRACK_LEN = 24,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         flip,
  input  logic [IMG_W-1:0]             center_img,
  input  logic [IMG_W-1:0]             edge_img,
  output logic [POS_W-1:0]             edge_addr,
  output logic [PLAYER_W-1:0]          player,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
  output logic                         match,
  output logic                         miss,
  output logic                         timeout,
  output logic                         game_over,
  output logic [PLAYER_W-1:0]          winner
);
  localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(TRACK_LEN - 1);
  localparam logic [POS_W-1:0] WIN_STEPS = POS_W'(TRACK_LEN);
  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || TRACK_LEN < NUM_PLAYERS || TRACK_LEN > 31 || TIMEOUT_CYCLES < 1)
    $error("turn_controller: parameter out of range");
  state_t r_state;
  logic [PLAYER_W-1:0] r_player, r_winner;
  logic [POS_W-1:0] r_pos [NUM_PLAYERS];
  logic [POS_W-1:0] r_steps [NUM_PLAYERS];
  logic [IMG_W-1:0] r_center, r_edge;
  logic r_match, r_miss, r_game_over;
  logic [PLAYER_W-1:0] w_next_player;
  logic [POS_W-1:0] w_cur_pos, w_new_steps;
  assign w_cur_pos = r_pos[r_player];
  assign edge_addr = (w_cur_pos == LAST_POS) ? '0 : w_cur_pos + 1'b1;
  assign w_next_player = (r_player == LAST_PLAYER) ? '0 : r_player + 1'b1;
  assign w_new_steps = r_steps[r_player] + 1'b1;
  assign player = r_player;
  assign match = r_match;
  assign miss = r_miss;
  assign game_over = r_game_over;
  assign winner = r_winner;
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pos
    assign pos_flat[g*POS_W +: POS_W] = r_pos[g];
  end
`ifdef TURN_TIMEOUT_EN
  logic r_timeout, w_expired, w_in_wait;
  assign w_in_wait = (r_state == WAIT_FLIP);
  assign timeout = r_timeout;
  // Leaving WAIT_FLIP holds the count at zero, so every entry starts a fresh turn window.
  turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(!w_in_wait),
    .en(w_in_wait),
    .expired(w_expired)
  );
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_player <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_pos[i] <= '0;
        r_steps[i] <= '0;
      end
      r_center <= '0;
      r_edge <= '0;
      r_match <= 1'b0;
      r_miss <= 1'b0;
      r_game_over <= 1'b0;
      r_winner <= '0;
`ifdef TURN_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_match <= 1'b0;
      r_miss <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE, DONE: if (start) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            r_pos[i] <= start_pos(i, TRACK_LEN, NUM_PLAYERS);
            r_steps[i] <= '0;
          end
          r_player <= '0;
          r_game_over <= 1'b0;
          r_winner <= '0;
          r_state <= WAIT_FLIP;
        end
        WAIT_FLIP: if (flip) begin
          r_center <= center_img;
          r_edge <= edge_img;
          r_state <= COMPARE;
        end
`ifdef TURN_TIMEOUT_EN
        else if (w_expired) begin
          r_timeout <= 1'b1;
          r_miss <= 1'b1;
          r_player <= w_next_player;
        end
`endif
        COMPARE: if (r_center == r_edge) begin
          r_match <= 1'b1;
          r_state <= ADVANCE;
        end else begin
          r_miss <= 1'b1;
          r_player <= w_next_player;
          r_state <= WAIT_FLIP;
        end
        ADVANCE: begin
          r_pos[r_player] <= edge_addr;
          r_steps[r_player] <= w_new_steps;
          r_game_over <= (w_new_steps == WIN_STEPS);
          r_winner <= (w_new_steps == WIN_STEPS) ? r_player : r_winner;
          r_state <= (w_new_steps == WIN_STEPS) ? DONE : WAIT_FLIP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: randomized self-checking bench with a game-rules reference model
module tb_turn_controller;
  localparam int NP = 4, TL = 24, TO = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flip = 1'b0;
  logic [3:0] center_img = '0, edge_img;
  logic [4:0] edge_addr;
  logic [1:0] player, winner;
  logic [NP*5-1:0] pos_flat;
  logic match, miss, timeout, game_over;
  logic [3:0] tiles [TL];
  int m_pos [NP];
  int m_steps [NP];
  int m_player = 0, m_over = 0, m_winner = 0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign edge_img = (edge_addr < TL) ? tiles[edge_addr] : 4'h0;
  turn_controller #(.NUM_PLAYERS(NP), .TRACK_LEN(TL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .flip(flip), .center_img(center_img),
    .edge_img(edge_img), .edge_addr(edge_addr), .player(player), .pos_flat(pos_flat),
    .match(match), .miss(miss), .timeout(timeout), .game_over(game_over), .winner(winner)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] exp_flat();
    logic [31:0] r = 0;
    for (int i = 0; i < NP; i++) r |= 32'(m_pos[i]) << (5 * i);
    return r;
  endfunction
  function automatic int ahead();
    return (m_pos[m_player] + 1) % TL;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin m_pos[i] = 0; m_steps[i] = 0; end
    m_player = 0; m_over = 0; m_winner = 0;
  endtask
  task automatic model_start();
    for (int i = 0; i < NP; i++) begin m_pos[i] = i * (TL / NP); m_steps[i] = 0; end
    m_player = 0; m_over = 0;
  endtask
  task automatic check_state(input string tag);
    check({tag, "_pos"}, pos_flat, exp_flat());
    check({tag, "_player"}, player, m_player);
    check({tag, "_addr"}, edge_addr, ahead());
    check({tag, "_over"}, game_over, m_over);
    if (m_over != 0) check({tag, "_winner"}, winner, m_winner);
  endtask
  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    check_state(tag);
  endtask
  task automatic model_step();
    m_pos[m_player] = (m_pos[m_player] + 1) % TL;
    m_steps[m_player]++;
    if (m_steps[m_player] == TL) begin m_over = 1; m_winner = m_player; end
  endtask
  // One flip: pulses appear one edge after the capturing edge, position one edge later.
  task automatic turn(input logic [3:0] c, input string tag);
    bit eq;
    eq = (c == tiles[ahead()]);
    flip = 1'b1;
    center_img = c;
    tick();
    flip = 1'b0;
    check({tag, "_early"}, {match, miss, timeout}, 0);
    tick();
    check({tag, "_match"}, match, eq);
    check({tag, "_miss"}, miss, !eq);
    check({tag, "_to"}, timeout, 0);
    if (!eq) m_player = (m_player + 1) % NP;
    else begin
      tick();
      check({tag, "_mdone"}, match, 0);
      model_step();
    end
    check_state(tag);
  endtask
  task automatic ignored_flip(input string tag);
    int hits = 0;
    flip = 1'b1;
    center_img = tiles[ahead()];
    tick();
    flip = 1'b0;
    for (int k = 0; k < 3; k++) begin hits += int'(match) + int'(miss); tick(); end
    check({tag, "_nopulse"}, hits, 0);
    check_state(tag);
  endtask
  initial begin
    int nm;
    for (int i = 0; i < TL; i++) tiles[i] = 4'($urandom_range(0, 15));
    tiles[1] = 4'd5;
    model_reset();
    tick();
    tick();
    check("rst_flags", {match, miss, timeout, game_over}, 0);
    check("rst_winner", winner, 0);
    check_state("rst");
    rst = 1'b0;
    // start and flip together in IDLE: start only
    start = 1'b1; flip = 1'b1; center_img = 4'd5;
    tick();
    start = 1'b0; flip = 1'b0;
    model_start();
    tick(); tick();
    check("startflip_nopulse", {match, miss}, 0);
    check_state("startflip");
    turn(4'd5, "first_match");
    for (int k = 0; k < 4; k++) turn(tiles[ahead()] ^ 4'h1, "miss_round");
    start = 1'b1;
    tick();
    start = 1'b0;
    check_state("start_ignored");
    // flip held for three cycles: exactly one match and one step
    nm = 0;
    flip = 1'b1;
    center_img = tiles[ahead()];
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) flip = 1'b0;
      nm += int'(match);
    end
    model_step();
    check("held_flip_matches", nm, 1);
    check_state("held_flip");
    // reset during COMPARE suppresses the pulse
    flip = 1'b1;
    center_img = tiles[ahead()];
    tick();
    flip = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_cmp_flags", {match, miss, timeout, game_over}, 0);
    check("rst_cmp_winner", winner, 0);
    check_state("rst_cmp");
    ignored_flip("idle_flip");
    // player 0 wins with consecutive matches, wrapping 23 -> 0
    do_start("win_start");
    for (int k = 0; k < TL; k++) turn(tiles[ahead()], "win_run");
    check("win_over", game_over, 1);
    ignored_flip("done_flip");
    do_start("restart");
    for (int t = 0; t < 700; t++) begin
      if (m_over != 0) begin
        ignored_flip("rand_done");
        do_start("rand_restart");
      end else if ($urandom_range(0, 1) == 1) turn(tiles[ahead()], "rand_hit");
      else turn(4'($urandom_range(0, 15)), "rand_any");
    end
`ifdef TURN_TIMEOUT_EN
    begin
      int first = -1;
      do_start("to_start");
      for (int k = 1; k <= 20 && first < 0; k++) begin
        tick();
        if (timeout) begin
          first = k;
          check("to_miss", miss, 1);
          m_player = (m_player + 1) % NP;
        end
      end
      check("to_cycle", first, TO);
      check_state("to_pass");
      for (int k = 1; k < TO; k++) begin
        tick();
        check("to_quiet", timeout, 0);
      end
      flip = 1'b1;
      center_img = tiles[ahead()];
      tick();
      flip = 1'b0;
      check("to_flipwins", {timeout, miss}, 0);
      tick();
      check("to_flip_match", match, 1);
      tick();
      model_step();
      check_state("to_flip");
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
